// File: rtl/capture_readout_queue.sv
// Capture readout queue: per-channel one-deep holding registers drained by a
// round-robin arbiter into a single registered valid/ready stream.
module capture_readout_queue #(
  parameter int TIMER_BITWIDTH   = 32,
  parameter int NB_CAPTURES      = 10,
  parameter int CHANNEL_BITWIDTH = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NB_CAPTURES-1:0]                capture_event_i,
  input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] captured_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [TIMER_BITWIDTH-1:0]             out_data_o,
  output logic [CHANNEL_BITWIDTH-1:0]           out_channel_o,
  output logic [NB_CAPTURES-1:0]                pending_o,
  output logic [NB_CAPTURES-1:0]                overflow_o,
  input  logic [NB_CAPTURES-1:0]                overflow_clr_i
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [CHANNEL_BITWIDTH-1:0] PTR_RESET = CHANNEL_BITWIDTH'(NB_CAPTURES - 1);

  logic [0:0]                          state_q, state_d;
  logic [TIMER_BITWIDTH-1:0]           data_q, data_d;
  logic [CHANNEL_BITWIDTH-1:0]         chan_q, chan_d;
  logic [CHANNEL_BITWIDTH-1:0]         ptr_q, ptr_d;
  logic [NB_CAPTURES-1:0]              pending_q, pending_d;
  logic [NB_CAPTURES-1:0]              overflow_q, overflow_d;
  logic [NB_CAPTURES-1:0]              granted;
  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] hold_flat;

  logic                                grant_found;
  logic [CHANNEL_BITWIDTH-1:0]         grant_idx;
  logic                                load;

  // First pending channel strictly after the last grant, wrapping modulo NB_CAPTURES.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NB_CAPTURES; i++) begin
      if (!grant_found && pending_q[(int'(ptr_q) + i) % NB_CAPTURES]) begin
        grant_found = 1'b1;
        grant_idx   = CHANNEL_BITWIDTH'((int'(ptr_q) + i) % NB_CAPTURES);
      end
    end
  end

  assign load = ((state_q == ST_EMPTY) || out_ready_i) && grant_found;

  for (genvar gi = 0; gi < NB_CAPTURES; gi++) begin : g_chan
    logic [TIMER_BITWIDTH-1:0] hold_q;
    logic                      ovf_set;

    assign granted[gi] = load && (grant_idx == CHANNEL_BITWIDTH'(gi));
    // A value is only lost when the old one is neither drained this cycle nor already gone.
    assign ovf_set       = capture_event_i[gi] && pending_q[gi] && !granted[gi];
    assign pending_d[gi]  = capture_event_i[gi] || (pending_q[gi] && !granted[gi]);
    assign overflow_d[gi] = ovf_set || (overflow_q[gi] && !overflow_clr_i[gi]);
    assign hold_flat[gi*TIMER_BITWIDTH +: TIMER_BITWIDTH] = hold_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hold_q <= '0;
      end else if (capture_event_i[gi]) begin
        hold_q <= captured_i[gi*TIMER_BITWIDTH +: TIMER_BITWIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
          data_d  = hold_flat[grant_idx*TIMER_BITWIDTH +: TIMER_BITWIDTH];
          chan_d  = grant_idx;
          ptr_d   = grant_idx;
        end
      end
      default: begin
        if (load) begin
          data_d = hold_flat[grant_idx*TIMER_BITWIDTH +: TIMER_BITWIDTH];
          chan_d = grant_idx;
          ptr_d  = grant_idx;
        end else if (out_ready_i) begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      data_q     <= '0;
      chan_q     <= '0;
      ptr_q      <= PTR_RESET;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid_o   = (state_q == ST_FULL);
  assign out_data_o    = data_q;
  assign out_channel_o = chan_q;
  assign pending_o     = pending_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_capture_readout_queue.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against a behavioural model of the capture/readout rules.
module tb_capture_readout_queue;

  localparam int W  = 32;
  localparam int NB = 10;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [NB-1:0]     capture_event_i = '0;
  logic [W*NB-1:0]   captured_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [W-1:0]      out_data_o;
  logic [CW-1:0]     out_channel_o;
  logic [NB-1:0]     pending_o;
  logic [NB-1:0]     overflow_o;
  logic [NB-1:0]     overflow_clr_i = '0;

  capture_readout_queue #(
    .TIMER_BITWIDTH(W), .NB_CAPTURES(NB), .CHANNEL_BITWIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .capture_event_i(capture_event_i),
    .captured_i(captured_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_channel_o(out_channel_o), .pending_o(pending_o),
    .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0]  m_hold [NB];
  logic [NB-1:0] m_pend;
  logic [NB-1:0] m_ovf;
  logic          m_valid;
  logic [W-1:0]  m_data;
  int            m_chan;
  int            m_ptr;
  bit            m_known = 0;

  // Words the DUT actually handed over, as {channel, data}
  logic [CW+W-1:0] dut_acc [$];

  function automatic logic [W*NB-1:0] one_cap(input int ch, input logic [W-1:0] v);
    logic [W*NB-1:0] r;
    r = '0;
    r[ch*W +: W] = v;
    return r;
  endfunction

  task automatic step(input logic r, input logic [NB-1:0] ev, input logic [W*NB-1:0] cap,
                      input logic rdy, input logic [NB-1:0] clr);
    int g;
    logic [NB-1:0] old_pend;
    logic set;
    @(negedge clk);
    if (m_known) begin
      check("valid", out_valid_o, m_valid);
      check("data", out_data_o, m_data);
      check("chan", out_channel_o, m_chan);
      check("pending", pending_o, m_pend);
      check("overflow", overflow_o, m_ovf);
    end
    if (out_valid_o && rdy && !r) begin
      dut_acc.push_back({out_channel_o, out_data_o});
      $display("XFER ch=%0d data=%08h t=%0t", out_channel_o, out_data_o, $time);
    end
    rst_i = r; capture_event_i = ev; captured_i = cap; out_ready_i = rdy; overflow_clr_i = clr;
    if (r) begin
      m_known = 1; m_valid = 0; m_data = '0; m_chan = 0; m_pend = '0; m_ovf = '0;
      m_ptr = NB - 1;
      for (int k = 0; k < NB; k++) m_hold[k] = '0;
    end else begin
      g = -1;
      if ((!m_valid || rdy) && m_pend != '0) begin
        for (int i = 1; i <= NB; i++) begin
          int c;
          c = (m_ptr + i) % NB;
          if (m_pend[c]) begin g = c; break; end
        end
      end
      if (g >= 0) begin
        m_valid = 1; m_data = m_hold[g]; m_chan = g; m_ptr = g;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      old_pend = m_pend;
      for (int k = 0; k < NB; k++) begin
        set = 0;
        if (ev[k]) begin
          set = old_pend[k] && (k != g);
          m_hold[k] = cap[k*W +: W];
          m_pend[k] = 1'b1;
        end else if (k == g) begin
          m_pend[k] = 1'b0;
        end
        if (set) m_ovf[k] = 1'b1;
        else if (clr[k]) m_ovf[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy, '0);
  endtask

  logic [NB-1:0]   ev_r, clr_r;
  logic [W*NB-1:0] cap_r;
  logic            rdy_r, rst_r;

  initial begin
    // Reset then idle
    step(1'b1, '0, '0, 1'b0, '0);
    step(1'b1, '0, '0, 1'b0, '0);
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_chan", out_channel_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_overflow", overflow_o, 0);
    dut_acc.delete();
    idle(20, 1'b1);
    check("idle_words", dut_acc.size(), 0);

    // Single capture on channel 3
    dut_acc.delete();
    step(1'b0, NB'(1) << 3, one_cap(3, 32'h0000_1234), 1'b1, '0);
    check("single_pend", pending_o[3], 1);
    check("single_early_valid", out_valid_o, 0);
    idle(1, 1'b1);
    check("single_valid", out_valid_o, 1);
    check("single_data", out_data_o, 32'h1234);
    check("single_chan", out_channel_o, 3);
    check("single_pend_clr", pending_o[3], 0);
    idle(4, 1'b1);
    check("single_count", dut_acc.size(), 1);

    // Round-robin fairness, twice (second burst wraps past channel 5)
    step(1'b1, '0, '0, 1'b0, '0);
    for (int rep = 0; rep < 2; rep++) begin
      dut_acc.delete();
      step(1'b0, NB'(10'b00_0010_0101),
           one_cap(0, 32'h100 + rep) | one_cap(2, 32'h200 + rep) | one_cap(5, 32'h500 + rep),
           1'b1, '0);
      idle(5, 1'b1);
      check("rr_count", dut_acc.size(), 3);
      check("rr_first", dut_acc[0][W +: CW], 0);
      check("rr_second", dut_acc[1][W +: CW], 2);
      check("rr_third", dut_acc[2][W +: CW], 5);
      check("rr_third_data", dut_acc[2][W-1:0], 32'h500 + rep);
    end

    // Backpressure and overflow on channel 1
    step(1'b0, NB'(1) << 9, one_cap(9, 32'h99), 1'b0, '0);
    idle(1, 1'b0);
    step(1'b0, NB'(1) << 1, one_cap(1, 32'hA), 1'b0, '0);
    step(1'b0, NB'(1) << 1, one_cap(1, 32'hB), 1'b0, '0);
    idle(1, 1'b0);
    check("bp_overflow", overflow_o[1], 1);
    check("bp_hold_valid", out_valid_o, 1);
    check("bp_hold_data", out_data_o, 32'h99);
    dut_acc.delete();
    idle(4, 1'b1);
    check("bp_count", dut_acc.size(), 2);
    check("bp_ch1_chan", dut_acc[1][W +: CW], 1);
    check("bp_ch1_data", dut_acc[1][W-1:0], 32'hB);
    step(1'b0, '0, '0, 1'b1, NB'(1) << 1);
    check("bp_ovf_clr", overflow_o[1], 0);

    // Grant and new event on channel 4 in the same cycle
    dut_acc.delete();
    step(1'b0, NB'(1) << 4, one_cap(4, 32'h10), 1'b1, '0);
    step(1'b0, NB'(1) << 4, one_cap(4, 32'h20), 1'b1, '0);
    idle(4, 1'b1);
    check("sim_count", dut_acc.size(), 2);
    check("sim_first", dut_acc[0][W-1:0], 32'h10);
    check("sim_second", dut_acc[1][W-1:0], 32'h20);
    check("sim_ovf", overflow_o[4], 0);

    // Reset mid-operation
    step(1'b0, NB'(1) << 5, one_cap(5, 32'h55), 1'b0, '0);
    idle(1, 1'b0);
    step(1'b0, NB'(3) << 6, one_cap(6, 32'h66) | one_cap(7, 32'h77), 1'b0, '0);
    idle(1, 1'b0);
    check("mid_valid_pre", out_valid_o, 1);
    check("mid_pend_pre", pending_o[7:6], 2'b11);
    step(1'b1, '0, '0, 1'b0, '0);
    check("mid_valid", out_valid_o, 0);
    check("mid_pending", pending_o, 0);
    check("mid_overflow", overflow_o, 0);
    dut_acc.delete();
    idle(10, 1'b1);
    check("mid_no_stale", dut_acc.size(), 0);

    // Random traffic with alternating fast and slow consumer phases
    for (int cyc = 0; cyc < 2400; cyc++) begin
      for (int k = 0; k < NB; k++) begin
        ev_r[k]       = ($urandom_range(0, 3) == 0);
        clr_r[k]      = ($urandom_range(0, 15) == 0);
        cap_r[k*W +: W] = $urandom;
      end
      rdy_r = ((cyc % 300) < 150) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      rst_r = ($urandom_range(0, 599) == 0);
      step(rst_r, ev_r, cap_r, rdy_r, clr_r);
    end
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_readout_queue.md
Name: capture_readout_queue

Overview:
- Downstream consumer of the timer capture block.
- Each capture event latches that channel's captured value into a one-deep per-channel holding register.
- A round-robin arbiter drains the pending values through a single valid/ready stream tagged with the channel index, for a host/bus interface to read.
- Per-channel sticky overflow flags report values lost to a slow consumer.

Parameters:
- TIMER_BITWIDTH, 32, width of each captured value.
- NB_CAPTURES, 10, number of capture channels (1..16).
- CHANNEL_BITWIDTH, 4, width of the channel tag; 2**CHANNEL_BITWIDTH >= NB_CAPTURES.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  synchronous reset, active-high.
- capture_event_i  in  NB_CAPTURES  one-cycle pulse per channel; the channel's slice of captured_i is valid in the same cycle.
- captured_i  in  TIMER_BITWIDTH*NB_CAPTURES  captured values from the timer; channel k occupies bits [k*TIMER_BITWIDTH +: TIMER_BITWIDTH].
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  consumer accepts the word when out_valid_o && out_ready_i.
- out_data_o  out  TIMER_BITWIDTH  captured value.
- out_channel_o  out  CHANNEL_BITWIDTH  source channel index.
- pending_o  out  NB_CAPTURES  per-channel "value waiting" flags.
- overflow_o  out  NB_CAPTURES  sticky per-channel overflow flags.
- overflow_clr_i  in  NB_CAPTURES  per-channel overflow clear, one-cycle pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state changes on the rising edge of clk_i.
- Reset (rst_i=1 on a clock edge) takes priority over every other input. After reset:
  - out_valid_o=0, out_data_o=0, out_channel_o=0.
  - pending_o=0, overflow_o=0, all holding registers=0.
  - Round-robin pointer = NB_CAPTURES-1, so channel 0 has first priority.
- Reset mid-transfer: a word held in the output register is discarded. No handshake completes on the reset cycle.
- Capture stage, per channel k, on capture_event_i[k]:
  - hold[k] <= captured_i slice k; pending[k] <= 1.
  - If pending[k] was already 1 and channel k is not granted in the same cycle: overwrite hold[k] (newest value wins) and set overflow[k].
  - If channel k is granted in the same cycle: the grant takes the old hold[k], the new value is stored, pending[k] stays 1, and overflow is not set.
- Overflow: overflow[k] stays set until overflow_clr_i[k]. If clear and a new overflow occur in the same cycle, set wins.
- Output register state machine, two states:
  - EMPTY (out_valid_o=0).
  - FULL (out_valid_o=1).
- load = (EMPTY or (FULL and out_ready_i)) and any pending.
- On load:
  - Grant the first pending channel found searching upward from pointer+1, modulo NB_CAPTURES.
  - out_data_o <= hold[g]; out_channel_o <= g; clear pending[g] unless re-set by a same-cycle event (see above); pointer <= g; state FULL.
- FULL with out_ready_i=1 and no pending channel: go to EMPTY. out_data_o and out_channel_o keep their last values.
- FULL with out_ready_i=0: out_data_o and out_channel_o stay stable (AXI-stream style; no retraction).
- Throughput and latency:
  - One word per cycle when the consumer holds out_ready_i=1 continuously.
  - Event at edge N gives pending at N+1; out_valid_o is high after edge N+1 at the earliest (one cycle after pending is visible).
- Combinational paths: no combinational path from out_ready_i to out_valid_o; out_valid_o is registered. out_ready_i is a don't-care while out_valid_o=0.
- Width rules:
  - out_channel_o is zero-extended to CHANNEL_BITWIDTH.
  - Values pass through unmodified; no arithmetic on data.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> all outputs 0; with no events, out_valid_o stays 0 for 20 cycles.
- Single capture: ch3 event with value 0x0000_1234, out_ready_i=1 -> exactly one word {ch=3, data=0x1234} two cycles after the event; pending_o[3] returns to 0.
- Round-robin fairness: ch0, ch2 and ch5 events in the same cycle, ready=1 -> output order ch0, ch2, ch5 on consecutive cycles. Repeating the burst after last grant=5 gives order ch0, ch2, ch5 again (wraps from 5).
- Backpressure and overflow: out_ready_i=0; ch1 receives 0xA then 0xB -> overflow_o[1]=1. Raise ready -> single word 0xB from ch1. Pulse overflow_clr_i[1] -> overflow_o[1]=0.
- Simultaneous grant and event: ch4 pending with 0x10, ready=1, and a ch4 event with 0x20 in the grant cycle -> words 0x10 then 0x20; overflow_o[4] stays 0.
- Reset mid-operation: out_valid_o=1 with ready=0 and ch6 and ch7 pending; assert rst_i -> next cycle out_valid_o=0, pending_o=0, overflow_o=0, and no stale word appears afterwards.
